tt_pin_wb_bridge: RTL

//  Parametrised tiny-tapeout-pin to Wishbone-classic master bridge: CPU drives 3-bit commands on uio_in[7:5]
//  and bytes on ui_in to build address/data, then launches single reads/writes (optionally auto-incrementing).

---
 rtl/tt_pin_wb_pkg.sv | 35 +++
 rtl/tt_pin_byte_ptr.sv | 30 +++
 rtl/tt_pin_wb_bridge.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/tt_pin_wb_pkg.sv
// Shared command codes, EXEC opcodes, status bit positions and FSM states
// for the tiny-tapeout pin to Wishbone bridge.
package tt_pin_wb_pkg;

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_EXEC = 3'b001;
  localparam logic [2:0] CMD_ADR  = 3'b010;
  localparam logic [2:0] CMD_DOUT = 3'b011;
  localparam logic [2:0] CMD_DIN  = 3'b100;
  localparam logic [2:0] CMD_STAT = 3'b101;

  localparam logic [7:0] EXE_RESET     = 8'h01;
  localparam logic [7:0] EXE_DISABLE   = 8'h04;
  localparam logic [7:0] EXE_ENABLE    = 8'h05;
  localparam logic [7:0] EXE_READ      = 8'h06;
  localparam logic [7:0] EXE_WRITE     = 8'h07;
  localparam logic [7:0] EXE_READ_INC  = 8'h0E;
  localparam logic [7:0] EXE_WRITE_INC = 8'h0F;

  localparam int STAT_BUSY  = 7;
  localparam int STAT_VALID = 6;
  localparam int STAT_ERR   = 5;
  localparam int STAT_TMO   = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Number of bytes needed to cover a field of the given bit width.
  function automatic int nbytes(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/tt_pin_byte_ptr.sv
// Byte pointer for multi-byte register access: reads 0 on the first cycle
// of a command run and advances on each further cycle, wrapping at N.
module tt_pin_byte_ptr #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          restart,
  input  logic          active,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] cnt;

  assign ptr = restart ? '0 : cnt;

  // Remember the byte index the next cycle of this run should use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (active) begin
      cnt <= (ptr == PW'(N - 1)) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/tt_pin_wb_bridge.sv
// Pin-level command interface that builds address/data a byte at a time and
// runs single Wishbone-classic transfers with timeout and error capture.
module tt_pin_wb_bridge #(
  parameter int ADR_W = 14,
  parameter int DAT_W = 32,
  parameter int TMO_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [7:0]         ui_in,
  output logic [7:0]         uo_out,
  input  logic [7:0]         uio_in,
  output logic [7:0]         uio_out,
  output logic [7:0]         uio_oe,
  output logic               wb_CYC,
  output logic               wb_STB,
  output logic               wb_WE,
  input  logic               wb_ACK,
  input  logic               wb_ERR,
  output logic [ADR_W-1:0]   wb_ADR,
  output logic [DAT_W/8-1:0] wb_SEL,
  output logic [DAT_W-1:0]   wb_DAT_MOSI,
  input  logic [DAT_W-1:0]   wb_DAT_MISO
);

  import tt_pin_wb_pkg::*;

  localparam int NB_D = DAT_W / 8;
  localparam int NB_A = nbytes(ADR_W);
  localparam int APW  = (NB_A > 1) ? $clog2(NB_A) : 1;
  localparam int DPW  = (NB_D > 1) ? $clog2(NB_D) : 1;

  logic [2:0]         cmd;
  logic [2:0]         cmd_last;
  logic               cmd_first;
  logic [APW-1:0]     adr_ptr;
  logic [DPW-1:0]     dat_ptr;
  state_t             state;
  state_t             state_next;
  logic               cyc_q, stb_q, we_q, inc_q;
  logic               valid_q, err_q, tmo_q, issued_q;
  logic [TMO_W-1:0]   timer_q;
  logic [ADR_W-1:0]   adr_q;
  logic [DAT_W-1:0]   do_q;
  logic [DAT_W-1:0]   di_q;
  logic [7:0]         uo_q;
  logic               is_exec, sync_clr, do_disable, do_enable, is_xfer;
  logic               launch, busy, bus_err, bus_ack, tmo_hit;
  logic [NB_A*8-1:0]  adr_wide;
  logic [DAT_W-1:0]   do_wide;
  logic [7:0]         din_byte;
  logic [7:0]         stat_byte;
  logic               unused_uio;

  assign unused_uio = |uio_in[4:0];

  assign cmd        = ena ? uio_in[7:5] : CMD_IDLE;
  assign cmd_first  = (cmd != cmd_last);
  assign busy       = (state == ST_BUSY);
  assign is_exec    = (cmd == CMD_EXEC);
  assign sync_clr   = is_exec && (ui_in == EXE_RESET);
  assign do_disable = is_exec && (ui_in == EXE_DISABLE);
  assign do_enable  = is_exec && (ui_in == EXE_ENABLE);
  assign is_xfer    = (ui_in == EXE_READ) || (ui_in == EXE_WRITE) ||
                      (ui_in == EXE_READ_INC) || (ui_in == EXE_WRITE_INC);
  assign launch     = is_exec && is_xfer && !issued_q && cyc_q && !busy;
  assign bus_err    = busy && wb_ERR;
  assign bus_ack    = busy && wb_ACK && !wb_ERR;
  assign tmo_hit    = busy && !wb_ACK && !wb_ERR &&
                      ((timer_q + TMO_W'(1)) == {TMO_W{1'b1}});

  tt_pin_byte_ptr #(.N(NB_A)) u_adr_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (sync_clr),
    .restart (cmd_first),
    .active  (cmd == CMD_ADR),
    .ptr     (adr_ptr)
  );

  tt_pin_byte_ptr #(.N(NB_D)) u_dat_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (sync_clr),
    .restart (cmd_first),
    .active  ((cmd == CMD_DOUT) || (cmd == CMD_DIN)),
    .ptr     (dat_ptr)
  );

  // Merge the incoming byte into the address/data registers and pick the read-back byte.
  always_comb begin
    adr_wide = '0;
    adr_wide[ADR_W-1:0] = adr_q;
    adr_wide[{adr_ptr, 3'b000} +: 8] = ui_in;
    do_wide = do_q;
    do_wide[{dat_ptr, 3'b000} +: 8] = ui_in;
    din_byte = di_q[{dat_ptr, 3'b000} +: 8];
  end

  // FSM state register; the RESET opcode behaves like the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (sync_clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: launch a transfer, then leave on ACK, ERR, timeout or DISABLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (launch) state_next = ST_BUSY;
      ST_BUSY: if (do_disable || bus_err || bus_ack || tmo_hit) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus controls, sticky flags, timer, address/data registers and the pin output byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_last <= CMD_IDLE;
      issued_q <= 1'b0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      inc_q    <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      timer_q  <= '0;
      adr_q    <= '0;
      do_q     <= '0;
      di_q     <= '0;
      uo_q     <= '0;
    end else if (sync_clr) begin
      cmd_last <= CMD_IDLE;
      issued_q <= 1'b0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      inc_q    <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      timer_q  <= '0;
      adr_q    <= '0;
      do_q     <= '0;
      di_q     <= '0;
      uo_q     <= '0;
    end else begin
      cmd_last <= cmd;
      if (!is_exec) begin
        issued_q <= 1'b0;
      end else if (launch) begin
        issued_q <= 1'b1;
      end
      if (do_enable) begin
        cyc_q <= 1'b1;
      end
      if (do_disable) begin
        cyc_q <= 1'b0;
        stb_q <= 1'b0;
        we_q  <= 1'b0;
      end else if (launch) begin
        stb_q   <= 1'b1;
        we_q    <= ui_in[0];
        inc_q   <= ui_in[3];
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        tmo_q   <= 1'b0;
        timer_q <= '0;
      end else if (busy) begin
        if (wb_ERR) begin
          stb_q <= 1'b0;
          we_q  <= 1'b0;
          err_q <= 1'b1;
        end else if (wb_ACK) begin
          stb_q   <= 1'b0;
          we_q    <= 1'b0;
          valid_q <= 1'b1;
          if (!we_q) di_q <= wb_DAT_MISO;
          if (inc_q) adr_q <= adr_q + ADR_W'(1);
        end else if (tmo_hit) begin
          stb_q <= 1'b0;
          we_q  <= 1'b0;
          err_q <= 1'b1;
          tmo_q <= 1'b1;
        end else begin
          timer_q <= timer_q + TMO_W'(1);
        end
      end
      if (!busy && (cmd == CMD_ADR)) begin
        adr_q <= adr_wide[ADR_W-1:0];
      end
      if (!busy && (cmd == CMD_DOUT)) begin
        do_q <= do_wide;
      end
      if (cmd == CMD_DIN) begin
        uo_q <= din_byte;
      end else if (cmd == CMD_STAT) begin
        uo_q <= stat_byte;
      end else begin
        uo_q <= di_q[7:0];
      end
    end
  end

  // Status byte and pin/bus output mapping.
  always_comb begin
    stat_byte             = '0;
    stat_byte[STAT_BUSY]  = busy;
    stat_byte[STAT_VALID] = valid_q;
    stat_byte[STAT_ERR]   = err_q;
    stat_byte[STAT_TMO]   = tmo_q;
    uio_out               = '0;
    uio_out[4]            = valid_q;
    uio_out[3]            = err_q;
    uio_oe                = 8'b0001_1000;
    uo_out                = uo_q;
    wb_CYC                = cyc_q;
    wb_STB                = stb_q;
    wb_WE                 = we_q;
    wb_SEL                = {NB_D{we_q}};
    wb_ADR                = adr_q;
    wb_DAT_MOSI           = do_q;
  end

endmodule
